// File: rtl/gpr_pkg.sv
// Shared GPR definitions for the writeback path.
package gpr_pkg;

    localparam int GPR_DATA_W = 16;
    localparam int GPR_ADDR_W = 3;
    localparam int GPR_COUNT  = 8;

    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
    typedef logic [GPR_DATA_W-1:0] gpr_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr_i wins.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          valid_o
);

    int          j;
    logic [PW-1:0] jj;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        jj      = '0;
        for (int k = 0; k < N; k++) begin
            j  = (int'(ptr_i) + k) % N;
            jj = PW'(j);
            if (en_i && !valid_o && req_i[jj]) begin
                grant_o[jj] = 1'b1;
                idx_o       = jj;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpr_write_arbiter.sv
// Round-robin share of the GPR write port with a registered output stage.
// GPR_R0_ZERO_EN: accept dest=0 writes but never pulse the write enable.
module gpr_write_arbiter
    import gpr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = GPR_DATA_W,
    parameter int ADDR_W  = GPR_ADDR_W,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      wr_stall,
    output logic                      reg_write_en,
    output logic [ADDR_W-1:0]         reg_write_dest,
    output logic [DATA_W-1:0]         reg_write_data,
    output logic [2**ADDR_W-1:0]      pend_mask,
    output logic [CNT_W-1:0]          contention_cnt,
    input  logic                      clr_cnt
);

    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG = 2**ADDR_W;

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      g_idx;
    logic               g_vld;
    logic [ADDR_W-1:0]  acc_dest;
    logic [DATA_W-1:0]  acc_data;
    logic               wr_ok;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .en_i    (reset_n && !wr_stall),
        .grant_o (grant),
        .idx_o   (g_idx),
        .valid_o (g_vld)
    );

    assign req_ready = grant;
    assign acc_dest  = req_dest[int'(g_idx)*ADDR_W +: ADDR_W];
    assign acc_data  = req_data[int'(g_idx)*DATA_W +: DATA_W];

`ifdef GPR_R0_ZERO_EN
    assign wr_ok = (acc_dest != '0);
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        en_d     = 1'b0;
        dest_d   = dest_q;
        data_d   = data_q;
        pend_d   = '0;
        cnt_d    = cnt_q;
        if (g_vld) begin
            rr_ptr_d = (int'(g_idx) == NUM_REQ-1) ? '0 : g_idx + 1'b1;
            en_d     = wr_ok;
            dest_d   = acc_dest;
            data_d   = acc_data;
            if (wr_ok)
                pend_d = {{(NREG-1){1'b0}}, 1'b1} << acc_dest;
        end
        // clear beats increment; increment saturates at all-ones
        if (clr_cnt)
            cnt_d = '0;
        else if ($countones(req_valid) >= 2 && !wr_stall && cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            en_q     <= 1'b0;
            dest_q   <= '0;
            data_q   <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            en_q     <= en_d;
            dest_q   <= dest_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    assign reg_write_en   = en_q;
    assign reg_write_dest = dest_q;
    assign reg_write_data = data_q;
    assign pend_mask      = pend_q;
    assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_gpr_write_arbiter.sv
// Self-checking bench for gpr_write_arbiter against a behavioural model.
module tb_gpr_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 16;
    localparam int NR = 8;
`ifdef GPR_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_dest;
    logic [N*DW-1:0] req_data;
    logic            wr_stall;
    logic            reg_write_en;
    logic [AW-1:0]   reg_write_dest;
    logic [DW-1:0]   reg_write_data;
    logic [NR-1:0]   pend_mask;
    logic [CW-1:0]   contention_cnt;
    logic            clr_cnt;

    always #5 clk = ~clk;

    gpr_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dest       (req_dest),
        .req_data       (req_data),
        .wr_stall       (wr_stall),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .pend_mask      (pend_mask),
        .contention_cnt (contention_cnt),
        .clr_cnt        (clr_cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    // behavioural model state
    int m_ptr, m_dest, m_data, m_cnt;
    bit m_en;

    function automatic int exp_grant();
        if (!reset_n || wr_stall) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g = exp_grant();
        return (g < 0) ? '0 : N'(1 << g);
    endfunction

    function automatic logic [NR-1:0] exp_pend();
        return m_en ? NR'(1 << m_dest) : '0;
    endfunction

    task automatic model_edge();
        int g, d, nv;
        if (!reset_n) begin
            m_ptr = 0; m_en = 0; m_dest = 0; m_data = 0; m_cnt = 0;
            return;
        end
        g = exp_grant();
        if (g >= 0) begin
            d      = int'(req_dest[g*AW +: AW]);
            m_en   = !(R0Z && d == 0);
            m_dest = d;
            m_data = int'(req_data[g*DW +: DW]);
            m_ptr  = (g + 1) % N;
        end else begin
            m_en = 0;
        end
        nv = 0;
        for (int i = 0; i < N; i++) nv += int'(req_valid[i]);
        if (clr_cnt) m_cnt = 0;
        else if (nv >= 2 && !wr_stall && m_cnt < (1 << CW) - 1) m_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input int i, input int d, input int v);
        req_valid[i]         = 1'b1;
        req_dest[i*AW +: AW] = AW'(d);
        req_data[i*DW +: DW] = DW'(v);
    endtask

    task automatic test_reset();
        reset_n = 0; wr_stall = 0; clr_cnt = 0;
        set_req(0, 1, 16'h1111); set_req(1, 2, 16'h2222); set_req(2, 3, 16'h3333);
        #1;
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_err++; $display("FAIL reset_ready got=%b exp=000", req_ready);
        end
        tick(); tick();
        n_checks++;
        if ({reg_write_en, reg_write_dest, reg_write_data, pend_mask, contention_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outs en=%b dest=%0d data=%h pend=%b cnt=%0d exp=all0",
                     reg_write_en, reg_write_dest, reg_write_data, pend_mask, contention_cnt);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        reset_n = 1;
        for (int c = 0; c < 6; c++) begin
            #0;
            want = N'(1 << (c % N));
            n_checks++;
            if (req_ready !== want || req_ready !== exp_ready()) begin
                n_err++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready, want);
            end
            tick();
            n_checks++;
            if (reg_write_en !== 1'b1 || reg_write_dest !== AW'(c % N + 1) ||
                reg_write_data !== DW'(16'h1111 * (c % N + 1))) begin
                n_err++;
                $display("FAIL rr_write c=%0d got en=%b dest=%0d data=%h exp en=1 dest=%0d",
                         c, reg_write_en, reg_write_dest, reg_write_data, c % N + 1);
            end
        end
        n_checks++;
        if (contention_cnt !== CW'(6) || m_cnt != 6) begin
            n_err++; $display("FAIL rr_cnt got=%0d exp=6", contention_cnt);
        end
        // reset mid-stream with requests still pending
        reset_n = 0;
        #1;
        n_checks++;
        if (req_ready !== '0) begin
            n_err++; $display("FAIL midrst_ready got=%b exp=000", req_ready);
        end
        tick();
        n_checks++;
        if (reg_write_en !== 1'b0 || contention_cnt !== '0) begin
            n_err++; $display("FAIL midrst_outs en=%b cnt=%0d exp en=0 cnt=0", reg_write_en, contention_cnt);
        end
        reset_n = 1;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_err++; $display("FAIL midrst_ptr got=%b exp=001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        req_valid = '0;
        set_req(1, 5, 16'hA5A5);
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_err++; $display("FAIL single_ready got=%b exp=010", req_ready);
        end
        tick();
        n_checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd5 ||
            reg_write_data !== 16'hA5A5 || pend_mask !== 8'b0010_0000) begin
            n_err++;
            $display("FAIL single_write got en=%b dest=%0d data=%h pend=%b exp en=1 dest=5 data=a5a5 pend=00100000",
                     reg_write_en, reg_write_dest, reg_write_data, pend_mask);
        end
        req_valid = '0;
        tick();
        n_checks++;
        if (reg_write_en !== 1'b0 || reg_write_dest !== 3'd5 ||
            reg_write_data !== 16'hA5A5 || pend_mask !== '0) begin
            n_err++;
            $display("FAIL single_hold got en=%b dest=%0d data=%h pend=%b exp en=0 dest=5 data=a5a5 pend=0",
                     reg_write_en, reg_write_dest, reg_write_data, pend_mask);
        end
    endtask

    task automatic test_stall();
        req_valid = '0;
        set_req(0, 6, 16'h0BEE);
        wr_stall = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (req_ready !== '0) begin
                n_err++; $display("FAIL stall_ready c=%0d got=%b exp=000", c, req_ready);
            end
            tick();
            n_checks++;
            if (reg_write_en !== 1'b0) begin
                n_err++; $display("FAIL stall_write c=%0d got en=%b exp=0", c, reg_write_en);
            end
        end
        wr_stall = 0;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_err++; $display("FAIL unstall_ready got=%b exp=001", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (reg_write_en !== 1'b1 || reg_write_dest !== 3'd6 || reg_write_data !== 16'h0BEE) begin
            n_err++;
            $display("FAIL unstall_write got en=%b dest=%0d data=%h exp en=1 dest=6 data=0bee",
                     reg_write_en, reg_write_dest, reg_write_data);
        end
        tick();
    endtask

    task automatic test_r0();
        req_valid = '0;
        set_req(0, 0, 16'h1234);
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_err++; $display("FAIL r0_ready got=%b exp=001", req_ready);
        end
        tick();
        n_checks++;
        if (reg_write_en !== !R0Z || pend_mask !== (R0Z ? 8'h00 : 8'h01) ||
            (!R0Z && reg_write_dest !== 3'd0)) begin
            n_err++;
            $display("FAIL r0_write got en=%b dest=%0d pend=%b exp en=%b",
                     reg_write_en, reg_write_dest, pend_mask, !R0Z);
        end
        set_req(0, 1, 16'h1); set_req(1, 2, 16'h2); set_req(2, 3, 16'h3);
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_err++; $display("FAIL r0_ptr got=%b exp=010", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        int g;
        int waits [N];
        for (int i = 0; i < N; i++) waits[i] = 0;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            wr_stall = ($urandom_range(0, 7) == 0);
            clr_cnt  = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, int'($urandom_range(0, NR-1)), int'($urandom_range(0, 65535)));
            #1;
            g = exp_grant();
            n_checks++;
            if (req_ready !== exp_ready()) begin
                n_err++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready());
            end
            tick();
            n_checks++;
            if (reg_write_en !== m_en || reg_write_dest !== AW'(m_dest) ||
                reg_write_data !== DW'(m_data) || pend_mask !== exp_pend() ||
                contention_cnt !== CW'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_out c=%0d got en=%b d=%0d v=%h p=%b n=%0d exp en=%b d=%0d v=%h p=%b n=%0d",
                         c, reg_write_en, reg_write_dest, reg_write_data, pend_mask, contention_cnt,
                         m_en, m_dest, m_data, exp_pend(), m_cnt);
            end
            if (g >= 0) begin
                for (int i = 0; i < N; i++)
                    if (i != g && req_valid[i]) waits[i]++;
                waits[g] = 0;
                req_valid[g] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (waits[i] >= N) begin
                    n_checks++; n_err++;
                    $display("FAIL starve req=%0d waited=%0d accepts", i, waits[i]);
                    waits[i] = 0;
                end
            end
        end
        wr_stall = 0; clr_cnt = 0; req_valid = '0;
        tick();
    endtask

    task automatic test_saturate();
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        req_valid = '0;
        set_req(0, 4, 16'h4444); set_req(1, 7, 16'h7777);
        for (int c = 0; c < (1 << CW) + 3; c++) tick();
        n_checks++;
        if (contention_cnt !== 16'hFFFF || m_cnt != 16'hFFFF) begin
            n_err++; $display("FAIL sat_cnt got=%h exp=ffff", contention_cnt);
        end
        clr_cnt = 1;
        tick();
        clr_cnt = 0;
        n_checks++;
        if (contention_cnt !== '0) begin
            n_err++; $display("FAIL clr_cnt got=%h exp=0000", contention_cnt);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        req_valid = '0; req_dest = '0; req_data = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_r0();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
